cacheline_adaptor: RTL and testbench

//   Memory-side counterpart of the cache data array: moves whole 256-bit lines between the

---
 rtl/cacheline_adaptor.sv | 129 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Cache line <-> burst memory adaptor.
// A read collects BEATS memory beats into one line for the data array fill.
// A write-back splits a victim line into BEATS beats, lowest beat first.
// Only one transaction is in flight at a time.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [LINE_W-1:0]   r_buf;
  logic [LINE_W-1:0]   r_line;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   w_fill;
  logic [BURST_W-1:0]  w_beat;
  logic [ADDR_W-1:0]   w_addr_aligned;
  logic                w_last;

  // Memory always sees whole-line addresses: the byte offset is dropped.
  assign w_addr_aligned = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_last         = resp_i && (r_count == LAST_BEAT);

  assign read_o    = (r_state == RD);
  assign write_o   = (r_state == WR);
  assign resp_o    = (r_state == DONE);
  assign address_o = r_addr;
  assign line_o    = r_line;
  assign burst_o   = w_beat;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; request inputs only matter in IDLE, read wins over write.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (read_i) begin
          w_state_nxt = RD;
        end else if (write_i) begin
          w_state_nxt = WR;
        end
      end
      RD:      if (w_last) w_state_nxt = DONE;
      WR:      if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat select for write data and beat insertion for read fill, both indexed by r_count.
  always_comb begin
    w_beat = '0;
    w_fill = r_buf;
    for (int b = 0; b < BEATS; b++) begin
      if (r_count == CNT_W'(b)) begin
        w_beat                       = r_buf[b*BURST_W +: BURST_W];
        w_fill[b*BURST_W +: BURST_W] = burst_i;
      end
    end
  end

  // Datapath: address/line capture at accept, beat counting, fill line publication.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_buf   <= '0;
      r_line  <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i) begin
            r_addr  <= w_addr_aligned;
            r_count <= '0;
          end else if (write_i) begin
            r_addr  <= w_addr_aligned;
            r_buf   <= line_i;
            r_count <= '0;
          end
        end
        RD: begin
          if (resp_i) begin
            r_buf   <= w_fill;
            r_count <= r_count + 1'b1;
            // Publish the line together with its final beat so it is valid during DONE.
            if (w_last) r_line <= w_fill;
          end
        end
        WR: begin
          if (resp_i) r_count <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor with hand-computed expected values.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int n_chk  = 0;
  int n_fail = 0;

  logic [255:0] r1_line, d_line, e_line, f_line, g_line, w_line, h_line;

  cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-wait line read; ln holds the beats the memory returns, ea the aligned address.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] ea,
                         input logic [255:0] ln);
    address_i = a;
    read_i    = 1'b1;
    tick();
    read_i    = 1'b0;
    address_i = 32'hFFFF_FFFF;
    chk({tag, " read_o on"}, read_o, 1'b1);
    chk({tag, " write_o off"}, write_o, 1'b0);
    chk({tag, " address_o"}, address_o, ea);
    resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      burst_i = ln[k*64 +: 64];
      chk({tag, " resp_o low in RD"}, resp_o, 1'b0);
      tick();
    end
    resp_i  = 1'b0;
    burst_i = '0;
    chk({tag, " resp_o pulse"}, resp_o, 1'b1);
    chk({tag, " read_o off in DONE"}, read_o, 1'b0);
    chk({tag, " line_o"}, line_o, ln);
    chk({tag, " address_o DONE"}, address_o, ea);
    tick();
    chk({tag, " resp_o single"}, resp_o, 1'b0);
    chk({tag, " line_o held"}, line_o, ln);
  endtask

  // Zero-wait line write; prev is the fill line that must be left untouched.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] ea,
                          input logic [255:0] ln, input logic [255:0] prev);
    address_i = a;
    line_i    = ln;
    write_i   = 1'b1;
    tick();
    write_i   = 1'b0;
    line_i    = '0;
    chk({tag, " write_o on"}, write_o, 1'b1);
    chk({tag, " read_o off"}, read_o, 1'b0);
    chk({tag, " address_o"}, address_o, ea);
    resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk({tag, " burst_o"}, burst_o, ln[k*64 +: 64]);
      tick();
    end
    resp_i = 1'b0;
    chk({tag, " resp_o pulse"}, resp_o, 1'b1);
    chk({tag, " write_o off"}, write_o, 1'b0);
    chk({tag, " line_o untouched"}, line_o, prev);
    tick();
    chk({tag, " resp_o single"}, resp_o, 1'b0);
  endtask

  initial begin
    r1_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    d_line  = {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF,
               64'hCAFE_F00D_1111_1111, 64'hDEAD_BEEF_0000_0000};
    e_line  = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
               64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
    f_line  = {64'h0F0F_0000_0000_0003, 64'h0F0F_0000_0000_0002,
               64'h0F0F_0000_0000_0001, 64'h0F0F_0000_0000_0000};
    g_line  = {64'h6666_0000_0000_6663, 64'h6666_0000_0000_6662,
               64'h6666_0000_0000_6661, 64'h6666_0000_0000_6660};
    w_line  = {64'h7777_7777_0000_0003, 64'h7777_7777_0000_0002,
               64'h7777_7777_0000_0001, 64'h7777_7777_0000_0000};
    h_line  = {64'h8888_1234_5678_0003, 64'h8888_1234_5678_0002,
               64'h8888_1234_5678_0001, 64'h8888_1234_5678_0000};

    rst = 1'b0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    line_i = '0; burst_i = '0; resp_i = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset read_o", read_o, 1'b0);
    chk("reset write_o", write_o, 1'b0);
    chk("reset resp_o", resp_o, 1'b0);
    chk("reset address_o", address_o, 32'h0);
    chk("reset line_o", line_o, 256'h0);
    chk("reset burst_o", burst_o, 64'h0);
    rst = 1'b1;
    tick();

    // Read, zero-wait: resp_o lands at cycle 5 after the request
    do_read("rd1", 32'h0000_1234, 32'h0000_1220, r1_line);

    // Write with two stall cycles before every beat
    address_i = 32'h0000_ABCF;
    line_i    = d_line;
    write_i   = 1'b1;
    tick();
    write_i   = 1'b0;
    line_i    = '0;
    chk("wrs address_o", address_o, 32'h0000_ABC0);
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 2; s++) begin
        chk("wrs stall burst_o", burst_o, d_line[k*64 +: 64]);
        chk("wrs stall write_o", write_o, 1'b1);
        chk("wrs read_o off", read_o, 1'b0);
        chk("wrs resp_o off", resp_o, 1'b0);
        tick();
      end
      resp_i = 1'b1;
      chk("wrs beat burst_o", burst_o, d_line[k*64 +: 64]);
      tick();
      resp_i = 1'b0;
    end
    chk("wrs resp_o pulse", resp_o, 1'b1);
    chk("wrs write_o off", write_o, 1'b0);
    chk("wrs read_o off DONE", read_o, 1'b0);
    chk("wrs line_o untouched", line_o, r1_line);
    tick();
    chk("wrs resp_o single", resp_o, 1'b0);
    chk("wrs address_o held", address_o, 32'h0000_ABC0);

    // Simultaneous read and write request: read wins
    address_i = 32'h2000_0010;
    line_i    = d_line;
    read_i    = 1'b1;
    write_i   = 1'b1;
    tick();
    read_i  = 1'b0;
    write_i = 1'b0;
    chk("both read_o", read_o, 1'b1);
    chk("both address_o", address_o, 32'h2000_0000);
    resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      burst_i = r1_line[(3-k)*64 +: 64];
      chk("both write_o off", write_o, 1'b0);
      tick();
    end
    resp_i = 1'b0;
    chk("both resp_o", resp_o, 1'b1);
    chk("both write_o off DONE", write_o, 1'b0);
    chk("both line_o", line_o, {r1_line[63:0], r1_line[127:64], r1_line[191:128], r1_line[255:192]});
    tick();

    // Asynchronous reset while beat 2 is on the bus
    address_i = 32'h0000_0047;
    read_i    = 1'b1;
    tick();
    read_i = 1'b0;
    resp_i = 1'b1;
    burst_i = e_line[63:0];
    tick();
    burst_i = e_line[127:64];
    tick();
    burst_i = e_line[191:128];
    #2 rst = 1'b0;
    #1;
    chk("async rst read_o", read_o, 1'b0);
    chk("async rst resp_o", resp_o, 1'b0);
    chk("async rst write_o", write_o, 1'b0);
    chk("async rst address_o", address_o, 32'h0);
    chk("async rst line_o", line_o, 256'h0);
    chk("async rst burst_o", burst_o, 64'h0);
    resp_i  = 1'b0;
    burst_i = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("post rst idle", read_o, 1'b0);
    do_read("rd after rst", 32'h0000_0047, 32'h0000_0040, f_line);

    // Spurious resp_i in IDLE, read_i held through DONE, spurious resp_i in DONE
    resp_i  = 1'b1;
    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    tick();
    chk("spur idle read_o", read_o, 1'b0);
    chk("spur idle resp_o", resp_o, 1'b0);
    chk("spur idle line_o", line_o, f_line);
    address_i = 32'h0000_0080;
    read_i    = 1'b1;
    tick();
    chk("held read_o", read_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      burst_i = g_line[k*64 +: 64];
      tick();
    end
    burst_i = 64'hBAD1_BAD1_BAD1_BAD1;
    chk("held resp_o", resp_o, 1'b1);
    chk("held line_o", line_o, g_line);
    tick();
    chk("held DONE single", resp_o, 1'b0);
    chk("held no restart in DONE", read_o, 1'b0);
    chk("held line_o after DONE", line_o, g_line);
    read_i = 1'b0;
    resp_i = 1'b0;
    tick();
    chk("held idle read_o", read_o, 1'b0);
    chk("held idle line_o", line_o, g_line);

    // Back-to-back write then read at the same address
    do_write("b2b wr", 32'h0000_5678, 32'h0000_5660, w_line, g_line);
    do_read("b2b rd", 32'h0000_5678, 32'h0000_5660, h_line);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
